truth_table_capture: RTL and testbench
======================================

Name: truth_table_capture

Overview:
- Sequential counterpart to the combinational mux-based truth-table implementations.
- A mux reads a truth table through its select lines. This block drives the select lines itself, reads back the function output Y, and rebuilds the table.
- It sweeps all 2^N_SEL input combinations, registers Y once per combination, and compares the captured table against an expected table.
- It sits beside a combinational function block as an on-chip self-check, replacing hand-written stimulus sequences.

Parameters:
- N_SEL, 3, width of the select/input vector driven to the function block.
- TABLE_W, 2**N_SEL, captured table width (derived; do not override).
- SETTLE, 1, clock cycles each select value is held before Y is sampled (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep.
- expected  input  TABLE_W  expected table; bit i is the expected Y for select value i.
- y_in  input  1  function-block output under test.
- sel_out  output  N_SEL  select/input vector driven to the function block.
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; level signal.
- table_out  output  TABLE_W  captured table; bit i is Y sampled at select value i.
- mismatch  output  TABLE_W  table_out XOR latched expected, valid while done=1.
- pass  output  1  1 when mismatch==0, valid while done=1.

Behaviour:
- Reset: all state is sampled on a clk edge with rst=1.
  - Next state is IDLE.
  - sel_out=0, busy=0, done=0, table_out=0, mismatch=0, pass=0, settle counter=0.
  - rst overrides start and applies in any state, including mid-sweep. No partial results are kept.
- States: IDLE, SWEEP, CHECK, DONE.
- IDLE:
  - start=1 at an edge: latch expected into an internal register, clear table_out and the settle counter, set sel_out=0 and busy=1, go to SWEEP.
- SWEEP:
  - Each select value is held for exactly SETTLE cycles.
  - On the edge that ends the window (settle counter == SETTLE-1): table_out[sel_out] <= y_in and the counter resets.
  - If sel_out == TABLE_W-1, go to CHECK with sel_out unchanged. Otherwise sel_out increments by 1.
  - Otherwise the counter increments.
  - y_in is sampled only on the window-end edge. Values in earlier cycles of the window are ignored (settling time).
- CHECK (one cycle), on the next edge:
  - mismatch <= table_out ^ expected_latched.
  - pass <= (table_out == expected_latched).
  - done <= 1, busy <= 0, sel_out <= 0, go to DONE.
- DONE:
  - Outputs hold until start or rst.
  - start=1: same action as start in IDLE (done, mismatch and pass cleared, new sweep begins).
- start while busy (SWEEP/CHECK) is ignored; no restart and no error.
- Changes to expected after the start edge have no effect on the current sweep.
- Latency:
  - With start sampled at edge E0, select value i is driven from E0+i*SETTLE until E0+(i+1)*SETTLE.
  - Y for value i is captured at E0+(i+1)*SETTLE.
  - done rises after edge E0+TABLE_W*SETTLE+1. Defaults give 9 edges.
- sel_out wraps only by returning to 0 in CHECK. It never counts past TABLE_W-1.

Test Plan:
1. Correct DUT, defaults:
   - Stimulus: bench models y_in = 8'h96[sel_out] combinationally, expected=8'h96, pulse start.
   - Required: sel_out steps 0..7, one value per cycle. done=1 after 9 edges with table_out=8'h96, mismatch=8'h00, pass=1, busy=0, sel_out=0.
2. Single-bit fault:
   - Stimulus: same as scenario 1, but y_in is inverted when sel_out=5.
   - Required: table_out=8'hB6, mismatch=8'h20, pass=0.
3. Ignored inputs during a sweep:
   - Stimulus: start pulsed again at edge E0+4, and expected changed to 8'h00 at E0+2.
   - Required: done still rises after E0+9, pass=1, table_out=8'h96.
4. Reset mid-sweep:
   - Stimulus: rst=1 for one cycle at E0+3.
   - Required: next cycle busy=0, done=0, sel_out=0, table_out=8'h00.
   - Then a fresh start completes normally with pass=1.
5. SETTLE=3 instance:
   - Stimulus: y_in driven wrong in the first 2 cycles of each window and correct in the third.
   - Required: each sel_out value held 3 cycles, pass=1, done after 25 edges.
6. Restart from DONE:
   - Stimulus: start asserted in the first cycle done=1.
   - Required: next cycle done=0, busy=1, sel_out=0, table_out=0, and the second sweep matches scenario 1 timing.

Source files
------------

// File: rtl/truth_table_capture.sv
// ---- truth_table_capture : drives select lines, captures Y per value, compares against expected table
// ---- Rev 1.0
`default_nettype none

module truth_table_capture #(
   parameter int N_SEL   = 3,
   parameter int TABLE_W = 2**N_SEL,
   parameter int SETTLE  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [TABLE_W-1:0] expected,
   input  logic               y_in,
   output logic [N_SEL-1:0]   sel_out,
   output logic               busy,
   output logic               done,
   output logic [TABLE_W-1:0] table_out,
   output logic [TABLE_W-1:0] mismatch,
   output logic               pass
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0]       C_SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [N_SEL-1:0] C_SEL_LAST    = N_SEL'(TABLE_W - 1);
   localparam logic [N_SEL-1:0] C_SEL_ONE     = N_SEL'(1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [3:0]         r_cnt;
   logic [3:0]         w_cnt_nxt;
   logic [TABLE_W-1:0] r_exp;
   logic [TABLE_W-1:0] w_exp_nxt;
   logic [TABLE_W-1:0] w_table_nxt;
   logic [TABLE_W-1:0] w_mism_nxt;
   logic [N_SEL-1:0]   w_sel_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;
   logic               w_pass_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= 4'd0;
         r_exp     <= '0;
         sel_out   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         table_out <= '0;
         mismatch  <= '0;
         pass      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_exp     <= w_exp_nxt;
         sel_out   <= w_sel_nxt;
         busy      <= w_busy_nxt;
         done      <= w_done_nxt;
         table_out <= w_table_nxt;
         mismatch  <= w_mism_nxt;
         pass      <= w_pass_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_exp_nxt   = r_exp;
      w_sel_nxt   = sel_out;
      w_busy_nxt  = busy;
      w_done_nxt  = done;
      w_table_nxt = table_out;
      w_mism_nxt  = mismatch;
      w_pass_nxt  = pass;

      case (r_state)
         IDLE, DONE: begin
            // A new sweep discards the previous verdict entirely.
            if (start) begin
               w_exp_nxt   = expected;
               w_table_nxt = '0;
               w_cnt_nxt   = 4'd0;
               w_sel_nxt   = '0;
               w_busy_nxt  = 1'b1;
               w_done_nxt  = 1'b0;
               w_mism_nxt  = '0;
               w_pass_nxt  = 1'b0;
               w_state_nxt = SWEEP;
            end
         end
         SWEEP: begin
            if (r_cnt == C_SETTLE_LAST) begin
               w_table_nxt[sel_out] = y_in;
               w_cnt_nxt            = 4'd0;
               if (sel_out == C_SEL_LAST) begin
                  w_state_nxt = CHECK;
               end else begin
                  w_sel_nxt = sel_out + C_SEL_ONE;
               end
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         CHECK: begin
            w_mism_nxt  = table_out ^ r_exp;
            w_pass_nxt  = (table_out == r_exp);
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_sel_nxt   = '0;
            w_state_nxt = DONE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_truth_table_capture.sv
// ---- tb_truth_table_capture : directed sweeps with a result scoreboard on SETTLE=1 and SETTLE=3 instances
// ---- Rev 1.0
`default_nettype none

module tb_truth_table_capture;

   typedef struct {
      logic [7:0] tbl;
      logic [7:0] mism;
      logic       pass;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start1;
   logic       start3;
   logic [7:0] exp1;
   logic [7:0] exp3;
   logic       fault;
   logic       y1;
   logic       y3;
   logic [7:0] pat;

   logic [2:0] sel1;
   logic       busy1;
   logic       done1;
   logic [7:0] tbl1;
   logic [7:0] mism1;
   logic       pass1;
   logic [2:0] sel3;
   logic       busy3;
   logic       done3;
   logic [7:0] tbl3;
   logic [7:0] mism3;
   logic       pass3;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   // Reference function block: the table bits of pat, optionally corrupted at select value 5.
   assign y1 = pat[sel1] ^ (fault && (sel1 == 3'd5));

   truth_table_capture #(.N_SEL(3), .SETTLE(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .expected(exp1), .y_in(y1),
      .sel_out(sel1), .busy(busy1), .done(done1), .table_out(tbl1),
      .mismatch(mism1), .pass(pass1)
   );

   truth_table_capture #(.N_SEL(3), .SETTLE(3)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .expected(exp3), .y_in(y3),
      .sel_out(sel3), .busy(busy3), .done(done3), .table_out(tbl3),
      .mismatch(mism3), .pass(pass3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   task automatic pop_check(input string tag, input logic [7:0] t, input logic [7:0] m, input logic p);
      exp_t x;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s_sb: observed empty scoreboard, expected an entry", tag);
      end else begin
         x = sb.pop_front();
         chk({tag, "_table"}, t, x.tbl);
         chk({tag, "_mismatch"}, m, x.mism);
         chk({tag, "_pass"}, p, x.pass);
      end
   endtask

   // Pulses start on dut1 (the sampling edge is E0) and records the result the sweep must produce.
   task automatic start1_sweep(input logic f, input logic [7:0] e);
      exp_t x;
      fault  = f;
      exp1   = e;
      x.tbl  = f ? (pat ^ 8'h20) : pat;
      x.mism = x.tbl ^ e;
      x.pass = (x.mism == 8'h00);
      sb.push_back(x);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("start_busy", busy1, 1);
      chk("start_done", done1, 0);
      chk("start_sel", sel1, 0);
      chk("start_table", tbl1, 0);
      chk("start_mismatch", mism1, 0);
      chk("start_pass", pass1, 0);
   endtask

   // Waits (bounded) for dut1 done, starting k0 edges after E0; checks sel stepping and latency.
   task automatic finish1(input int k0, input int lat);
      int k = k0;
      while (!done1 && k < 40) begin
         tick();
         k++;
         if (!done1) chk("sel_step", sel1, (k < 8) ? k : 7);
      end
      chk("done_latency", k, lat);
      chk("done_busy", busy1, 0);
      chk("done_sel", sel1, 0);
      pop_check("sweep1", tbl1, mism1, pass1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion, expected $finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst    = 1'b1;
      start1 = 1'b0;
      start3 = 1'b0;
      exp1   = 8'h00;
      exp3   = 8'h00;
      fault  = 1'b0;
      y3     = 1'b0;
      pat    = 8'h96;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_sel", sel1, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_table", tbl1, 0);
      chk("rst_mismatch", mism1, 0);
      chk("rst_pass", pass1, 0);
      chk("rst3_busy", busy3, 0);
      chk("rst3_done", done3, 0);

      // Correct function, default timing.
      start1_sweep(1'b0, 8'h96);
      finish1(0, 9);

      // Restart in the first cycle done is high.
      start1_sweep(1'b0, 8'h96);
      finish1(0, 9);

      // Single-bit fault at select value 5, then results must hold while idle in DONE.
      start1_sweep(1'b1, 8'h96);
      finish1(0, 9);
      fault = 1'b0;
      tick();
      tick();
      tick();
      chk("hold_done", done1, 1);
      chk("hold_table", tbl1, 8'hB6);
      chk("hold_mismatch", mism1, 8'h20);
      chk("hold_pass", pass1, 0);

      // Start and expected changes during a sweep are ignored.
      start1_sweep(1'b0, 8'h96);
      tick();
      tick();
      exp1 = 8'h00;
      tick();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("ignore_sel", sel1, 4);
      chk("ignore_busy", busy1, 1);
      finish1(4, 9);
      chk("ignore_table_literal", tbl1, 8'h96);

      // Reset at E0+3 discards the partial sweep.
      start1_sweep(1'b0, 8'h96);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", busy1, 0);
      chk("midrst_done", done1, 0);
      chk("midrst_sel", sel1, 0);
      chk("midrst_table", tbl1, 0);
      void'(sb.pop_back());
      tick();
      chk("midrst_idle_busy", busy1, 0);
      start1_sweep(1'b0, 8'h96);
      finish1(0, 9);

      // SETTLE=3: y is wrong for the first two cycles of every window.
      begin
         exp_t x;
         int   k = 0;
         x.tbl  = pat;
         x.mism = 8'h00;
         x.pass = 1'b1;
         sb.push_back(x);
         exp3   = 8'h96;
         start3 = 1'b1;
         tick();
         start3 = 1'b0;
         chk("s3_start_busy", busy3, 1);
         while (!done3 && k < 80) begin
            chk("s3_sel_hold", sel3, ((k / 3) < 8) ? (k / 3) : 7);
            y3 = ((k % 3) == 2) ? pat[sel3] : ~pat[sel3];
            tick();
            k++;
         end
         chk("s3_latency", k, 25);
         chk("s3_busy", busy3, 0);
         pop_check("sweep3", tbl3, mism3, pass3);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
